// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg
//   Shared definitions for the stream demultiplexer:
//   - FIFO_DEPTH / PTR_LEN : geometry of each per-channel FIFO
//   - level_t / LEVEL_FULL : occupancy type and its "full" value
//   - slice_lo()           : low bit of channel k within a flattened bus
package stream_demux_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int PTR_LEN    = 1;

    typedef logic [1:0] level_t;

    localparam level_t LEVEL_FULL = level_t'(FIFO_DEPTH);

    // Offset of channel k inside a bus that packs all channels side by side.
    function automatic int slice_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/stream_demux_chan.sv
// stream_demux_chan
//   One output channel of the demultiplexer: a 2-entry FIFO plus a counter
//   of completed output handshakes.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data into the FIFO this cycle
//   push_data   : payload to store
//   out_ready   : downstream ready for this channel
//   out_valid   : FIFO not empty (head presented on out_data)
//   out_data    : FIFO head; holds the last popped beat while empty
//   level       : current occupancy (0..2)
//   xfer_cnt    : wrapping count of output handshakes
module stream_demux_chan
    import stream_demux_pkg::*;
#(
    parameter int DATA_LEN = 2,
    parameter int CNT_LEN  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [DATA_LEN-1:0] push_data,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [DATA_LEN-1:0] out_data,
    output level_t              level,
    output logic [CNT_LEN-1:0]  xfer_cnt
);

    logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
    logic [PTR_LEN-1:0]  rd_ptr;
    logic [PTR_LEN-1:0]  wr_ptr;
    logic                pop;

    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // When the last beat leaves without a replacement, the read pointer moves
    // onto the free slot; copying the departing head there keeps out_data
    // steady while the channel sits empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            xfer_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end else if (pop && level == level_t'(1)) begin
                mem[wr_ptr] <= mem[rd_ptr];
            end

            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                xfer_cnt <= xfer_cnt + 1'b1;
            end

            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/stream_demux.sv
// stream_demux
//   1-to-NR_OUT valid/ready demultiplexer. Each input beat is routed by
//   in_key into a per-channel 2-entry FIFO, so one stalled sink does not
//   block traffic for the others.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : input beat valid
//   in_ready   : a beat for in_key can be accepted this cycle
//   in_key     : destination channel
//   in_data    : payload
//   out_valid  : per-channel valid, bit k = channel k
//   out_ready  : per-channel ready
//   out_data   : channel k at [k*DATA_LEN +: DATA_LEN]
//   xfer_cnt   : channel k at [k*CNT_LEN +: CNT_LEN], output handshake count
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int NR_OUT   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 2,
    parameter int CNT_LEN  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [KEY_LEN-1:0]         in_key,
    input  logic [DATA_LEN-1:0]        in_data,
    output logic [NR_OUT-1:0]          out_valid,
    input  logic [NR_OUT-1:0]          out_ready,
    output logic [NR_OUT*DATA_LEN-1:0] out_data,
    output logic [NR_OUT*CNT_LEN-1:0]  xfer_cnt
);

    level_t level [NR_OUT];
    logic   accept;

    // A full channel can still take a beat when its head leaves in the same
    // cycle; reset holds the input closed.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            in_ready = (level[in_key] < LEVEL_FULL) ||
                       (level[in_key] == LEVEL_FULL && out_ready[in_key]);
        end
    end

    assign accept = in_valid && in_ready;

    for (genvar k = 0; k < NR_OUT; k++) begin : g_chan
        stream_demux_chan #(
            .DATA_LEN (DATA_LEN),
            .CNT_LEN  (CNT_LEN)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (accept && (in_key == KEY_LEN'(k))),
            .push_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[slice_lo(k, DATA_LEN) +: DATA_LEN]),
            .level     (level[k]),
            .xfer_cnt  (xfer_cnt[slice_lo(k, CNT_LEN) +: CNT_LEN])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux
//   Directed stimulus for stream_demux with a per-channel scoreboard:
//   accepted beats are queued by key and compared when each channel hands
//   them out; in_ready, out_valid, out_data and xfer_cnt are checked against
//   the bench's own model every cycle.
`timescale 1ns/1ps
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_key;
    logic [1:0] in_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
    logic [31:0] xfer_cnt;

    int check_count = 0;
    int pass_count  = 0;

    // Scoreboard and reference model state, one entry per channel.
    logic [1:0] exp_q [4][$];
    logic [1:0] last_data [4];
    logic [7:0] model_cnt [4];

    stream_demux #(
        .NR_OUT   (4),
        .KEY_LEN  (2),
        .DATA_LEN (2),
        .CNT_LEN  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .xfer_cnt  (xfer_cnt)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] key,
                                 input logic [1:0] data, input logic [3:0] ordy);
        in_valid  = valid;
        in_key    = key;
        in_data   = data;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        logic [3:0] exp_valid;
        logic [7:0] exp_data;
        logic [31:0] exp_cnt;
        logic       exp_ready;
        int         sz;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                exp_q[k].delete();
                last_data[k] = '0;
                model_cnt[k] = '0;
            end
            checkOutput("reset_out_valid", {28'd0, out_valid}, 32'd0);
            checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("reset_out_data", {24'd0, out_data}, 32'd0);
            checkOutput("reset_xfer_cnt", xfer_cnt, 32'd0);
        end else begin
            sz = exp_q[in_key].size();
            exp_ready = (sz < 2) || (sz == 2 && out_ready[in_key]);
            for (int k = 0; k < 4; k++) begin
                exp_valid[k] = (exp_q[k].size() != 0);
                exp_data[k*2 +: 2] = exp_valid[k] ? exp_q[k][0] : last_data[k];
                exp_cnt[k*8 +: 8] = model_cnt[k];
            end
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            checkOutput("out_valid", {28'd0, out_valid}, {28'd0, exp_valid});
            checkOutput("out_data", {24'd0, out_data}, {24'd0, exp_data});
            checkOutput("xfer_cnt", xfer_cnt, exp_cnt);
            for (int k = 0; k < 4; k++) begin
                if (exp_valid[k] && out_ready[k]) begin
                    last_data[k] = exp_q[k].pop_front();
                    model_cnt[k] = model_cnt[k] + 8'd1;
                end
            end
            if (in_valid && exp_ready) begin
                exp_q[in_key].push_back(in_data);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 2'd0, 2'd0, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Empty after reset: every key accepts.
        for (int k = 0; k < 4; k++) begin
            in_key = 2'(k);
            #1;
            checkOutput("ready_after_reset", {31'd0, in_ready}, 32'd1);
        end
        tick();

        // Single beat to channel 1, one-cycle latency, then drained.
        applyStimulus(1'b1, 2'd1, 2'd3, 4'hF);
        tick();
        applyStimulus(1'b0, 2'd0, 2'd0, 4'hF);
        checkOutput("single_valid", {28'd0, out_valid}, 32'h2);
        checkOutput("single_data", {30'd0, out_data[3:2]}, 32'd3);
        tick();
        checkOutput("single_drained", {28'd0, out_valid}, 32'd0);
        checkOutput("single_cnt", {24'd0, xfer_cnt[15:8]}, 32'd1);

        // Backpressure on channel 3, then the stalled beat redirected to 0.
        applyStimulus(1'b1, 2'd3, 2'd1, 4'b0111);
        tick();
        applyStimulus(1'b1, 2'd3, 2'd2, 4'b0111);
        tick();
        applyStimulus(1'b1, 2'd3, 2'd3, 4'b0111);
        #1;
        checkOutput("bp_full_ready", {31'd0, in_ready}, 32'd0);
        tick();
        checkOutput("bp_still_stalled", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b1, 2'd0, 2'd3, 4'b0111);
        #1;
        checkOutput("bp_redirect_ready", {31'd0, in_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 2'd3, 2'd0, 4'b0111);
        checkOutput("bp_valid", {28'd0, out_valid}, 32'h9);
        tick();

        // Full channel 3 (1,2): push 3 while popping 1.
        applyStimulus(1'b1, 2'd3, 2'd3, 4'hF);
        #1;
        checkOutput("fullpop_ready", {31'd0, in_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 2'd3, 2'd0, 4'b0111);
        checkOutput("fullpop_head", {30'd0, out_data[7:6]}, 32'd2);
        #1;
        checkOutput("fullpop_still_full", {31'd0, in_ready}, 32'd0);
        tick();
        applyStimulus(1'b0, 2'd0, 2'd0, 4'hF);
        tick();
        checkOutput("fullpop_second", {30'd0, out_data[7:6]}, 32'd3);
        tick();
        checkOutput("fullpop_empty", {28'd0, out_valid}, 32'd0);

        // One beat parked in each channel, then all drained together.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 2'(k), 2'(3 - k), 4'h0);
            tick();
        end
        applyStimulus(1'b0, 2'd0, 2'd0, 4'hF);
        checkOutput("parallel_loaded", {28'd0, out_valid}, 32'hF);
        tick();
        checkOutput("parallel_drained", {28'd0, out_valid}, 32'd0);

        // Reset while channel 2 holds two beats.
        applyStimulus(1'b1, 2'd2, 2'd1, 4'b1011);
        tick();
        applyStimulus(1'b1, 2'd2, 2'd2, 4'b1011);
        tick();
        applyStimulus(1'b0, 2'd0, 2'd0, 4'b1011);
        checkOutput("pre_reset_valid", {31'd0, out_valid[2]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", {31'd0, out_valid[2]}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'd0, 2'd0, 4'hF);
        tick();
        checkOutput("no_replay", {28'd0, out_valid}, 32'd0);

        // 256 handshakes on channel 0 wrap its counter back to zero.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 2'd0, i[1:0], 4'hF);
            tick();
        end
        applyStimulus(1'b0, 2'd0, 2'd0, 4'hF);
        tick();
        tick();
        checkOutput("wrap_cnt", xfer_cnt, 32'd0);
        checkOutput("wrap_idle", {28'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
